// File: rtl/sggoc_trace_pkg.sv
// Shared definitions for the Z80 bus trace recorder:
// record layout, bus cycle type codes and type-mask helpers.
package sggoc_trace_pkg;

    typedef enum logic [1:0] {
        TR_MEM_RD = 2'd0,
        TR_MEM_WR = 2'd1,
        TR_IO_RD  = 2'd2,
        TR_IO_WR  = 2'd3
    } tr_type_e;

    localparam int REC_W        = 32;
    localparam int REC_TYPE_LSB = 30;
    localparam int REC_TYPE_W   = 2;
    localparam int REC_HIT_LSB  = 24;
    localparam int REC_HIT_W    = 6;
    localparam int REC_ADDR_LSB = 8;
    localparam int REC_ADDR_W   = 16;
    localparam int REC_DATA_LSB = 0;
    localparam int REC_DATA_W   = 8;

    // Mask bit order is {io_wr, io_rd, mem_wr, mem_rd}
    function automatic logic [3:0] type_mask_bit(input tr_type_e t);
        return 4'b0001 << t;
    endfunction

    function automatic logic [REC_W-1:0] make_rec(
        input tr_type_e              t,
        input logic [REC_HIT_W-1:0]  hits,
        input logic [REC_ADDR_W-1:0] addr,
        input logic [REC_DATA_W-1:0] data
    );
        return {t, hits, addr, data};
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// First-word-fall-through trace FIFO with optional ring
// (overwrite-oldest) behaviour and a sticky loss flag.
module trace_fifo #(
    parameter int DEPTH = 64,
    parameter int WIDTH = 32,
    parameter int RING  = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_data,
    input  logic                     i_pop,
    input  logic                     i_clr,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_valid,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;

    logic w_full;
    logic w_empty;
    logic w_pop;
    logic w_wr;
    logic w_drop_head;
    logic w_lost;
    logic w_inc;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_pop   = i_pop && !w_empty;

    // A full FIFO accepts a push only if a pop frees a slot or in ring mode
    assign w_wr        = i_push && (!w_full || w_pop || (RING != 0));
    assign w_drop_head = i_push && w_full && !w_pop && (RING != 0);
    assign w_lost      = i_push && w_full && !w_pop;
    assign w_inc       = w_wr && !w_drop_head;

    // Storage array; no reset, contents qualified by count
    always_ff @(posedge clk) begin
        if (w_wr && !i_clr)
            r_mem[r_wptr] <= i_data;
    end

    // Pointer, occupancy and overflow bookkeeping; clr wins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else if (i_clr) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_ovf   <= 1'b0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + AW'(1);
            if (w_pop || w_drop_head)
                r_rptr <= r_rptr + AW'(1);
            if (w_inc && !w_pop)
                r_count <= r_count + CW'(1);
            else if (!w_inc && w_pop)
                r_count <= r_count - CW'(1);
            if (w_lost)
                r_ovf <= 1'b1;
        end
    end

    assign o_data     = r_mem[r_rptr];
    assign o_valid    = !w_empty;
    assign o_count    = r_count;
    assign o_full     = w_full;
    assign o_overflow = r_ovf;

endmodule

// File: rtl/z80_bus_trace.sv
// Z80 bus event recorder: tracks strobes, filters through address
// windows, queues 32-bit records and latches debug port writes.
module z80_bus_trace
    import sggoc_trace_pkg::*;
#(
    parameter int         DEPTH      = 64,
    parameter int         NUM_MATCH  = 2,
    parameter int         RING       = 1,
    parameter logic [7:0] DEBUG_PORT = 8'h01
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [15:0]               z80_addr,
    input  logic [7:0]                z80_do,
    input  logic [7:0]                z80_di,
    input  logic                      z80_mem_rd,
    input  logic                      z80_mem_wr,
    input  logic                      z80_io_rd,
    input  logic                      z80_io_wr,
    input  logic [NUM_MATCH-1:0]      match_en,
    input  logic [16*NUM_MATCH-1:0]   match_lo,
    input  logic [16*NUM_MATCH-1:0]   match_hi,
    input  logic [4*NUM_MATCH-1:0]    match_types,
    input  logic                      rd_en,
    output logic [31:0]               rd_data,
    output logic                      rd_valid,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      overflow,
    input  logic                      clr,
    output logic [7:0]                dbg_data
);

    logic [3:0]           w_strb;
    logic                 w_any;
    tr_type_e             w_type;
    logic [7:0]           w_data;
    logic [NUM_MATCH-1:0] w_hit;
    logic [REC_HIT_W-1:0] w_hit_ext;
    logic                 w_pass;
    logic                 w_rise;
    logic                 w_hold;
    logic                 w_end;
    logic                 w_push;
    logic [REC_W-1:0]     w_rec;

    logic [3:0]           r_prev_strb;
    logic                 r_block;
    logic                 r_active;
    tr_type_e             r_type;
    logic [15:0]          r_addr;
    logic [7:0]           r_data;
    logic [REC_HIT_W-1:0] r_hit;
    logic                 r_pass;
    logic [7:0]           r_dbg;

    assign w_strb = {z80_io_wr, z80_io_rd, z80_mem_wr, z80_mem_rd};
    assign w_any  = |w_strb;

    // Encode the active strobe as a record type code
    always_comb begin
        w_type = TR_MEM_RD;
        if (z80_mem_wr)
            w_type = TR_MEM_WR;
        else if (z80_io_rd)
            w_type = TR_IO_RD;
        else if (z80_io_wr)
            w_type = TR_IO_WR;
    end

    assign w_data = (z80_mem_wr || z80_io_wr) ? z80_do : z80_di;

    genvar g;
    generate
        for (g = 0; g < NUM_MATCH; g++) begin : g_match
            logic [15:0] w_lo;
            logic [15:0] w_hi;
            logic [3:0]  w_tm;
            assign w_lo = match_lo[16*g +: 16];
            assign w_hi = match_hi[16*g +: 16];
            assign w_tm = match_types[4*g +: 4];
            assign w_hit[g] = match_en[g]
                && (w_lo <= z80_addr)
                && (z80_addr <= w_hi)
                && |(w_tm & type_mask_bit(w_type));
        end
    endgenerate

    assign w_hit_ext = REC_HIT_W'(w_hit);
    assign w_pass    = (match_en == '0) || (|w_hit);

    // A change of strobe pattern ends the tracked cycle and may start another
    assign w_rise = w_any && (w_strb != r_prev_strb) && !r_block;
    assign w_hold = r_active && (w_strb == r_prev_strb);
    assign w_end  = r_active && (w_strb != r_prev_strb);
    assign w_push = w_end && r_pass;
    assign w_rec  = make_rec(r_type, r_hit, r_addr, r_data);

    // Track the live bus cycle; r_block hides a strobe held across reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_prev_strb <= '0;
            r_block     <= 1'b1;
            r_active    <= 1'b0;
            r_type      <= TR_MEM_RD;
            r_addr      <= '0;
            r_data      <= '0;
            r_hit       <= '0;
            r_pass      <= 1'b0;
        end else begin
            r_prev_strb <= w_strb;
            r_block     <= 1'b0;
            if (w_rise || w_hold) begin
                r_active <= 1'b1;
                r_type   <= w_type;
                r_addr   <= z80_addr;
                r_data   <= w_data;
                r_hit    <= w_hit_ext;
                r_pass   <= w_pass;
            end else begin
                r_active <= 1'b0;
            end
        end
    end

    // Debug port latch, independent of the capture filters
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_dbg <= 8'h00;
        else if (z80_io_wr && (z80_addr[7:0] == DEBUG_PORT))
            r_dbg <= z80_do;
    end

    assign dbg_data = r_dbg;

    trace_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REC_W),
        .RING  (RING)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_push     (w_push),
        .i_data     (w_rec),
        .i_pop      (rd_en),
        .i_clr      (clr),
        .o_data     (rd_data),
        .o_valid    (rd_valid),
        .o_count    (count),
        .o_full     (full),
        .o_overflow (overflow)
    );

endmodule

// File: doc/z80_bus_trace.md
# z80_bus_trace

Parametrised, synthesizable Z80 bus event recorder for the sggoc system. It sits beside the MMU on the decoded Z80 strobes (mem/io read/write) and captures each completed bus cycle as a 32-bit record into an on-chip trace FIFO. Capture is filtered by NUM_MATCH programmable address/type windows. The block also latches writes to a debug I/O port, so the same capture works on hardware and in simulation.

## Interface
Parameters:
- DEPTH, 64: trace FIFO entries; power of two, 2..1024.
- NUM_MATCH, 2: number of address-match channels, 1..6.
- RING, 1: 1 = overwrite oldest entry when full; 0 = stop (drop newest) when full.
- DEBUG_PORT, 8'h01: I/O port whose writes are latched into dbg_data.

Ports:
- clk  in  1  Z80 clock. One clock domain.
- rst  in  1  Reset, asynchronous, active-high.
- z80_addr  in  16  Z80 address bus.
- z80_do  in  8  Z80 write data.
- z80_di  in  8  Z80 read data, as returned by the MMU.
- z80_mem_rd, z80_mem_wr, z80_io_rd, z80_io_wr  in  1 each  Decoded bus strobes. At most one is high at a time.
- match_en  in  NUM_MATCH  Per-channel enable.
- match_lo, match_hi  in  16*NUM_MATCH  Inclusive address window per channel. Channel i uses bits [16i+15:16i].
- match_types  in  4*NUM_MATCH  Per-channel type mask. Bit order: {io_wr, io_rd, mem_wr, mem_rd}.
- rd_en  in  1  Pop the head entry.
- rd_data  out  32  Head record, first-word-fall-through.
- rd_valid  out  1  FIFO not empty.
- count  out  $clog2(DEPTH)+1  Number of occupied entries.
- full  out  1  count == DEPTH.
- overflow  out  1  Sticky flag: an event was lost or overwritten.
- clr  in  1  Synchronous flush.
- dbg_data  out  8  Last value written to DEBUG_PORT.

## Operation
- Record format: [31:30] type (00 mem_rd, 01 mem_wr, 10 io_rd, 11 io_wr); [29:24] channel-hit bitmask, zero-extended, unused bits 0; [23:8] address; [7:0] data.
- Data field is z80_do for writes and z80_di for reads.
- Event tracking: while a strobe is high, the block registers the type, address, data and hit mask every cycle. When the strobe falls, the last registered values form the event. An immediate change from one strobe type to another counts as a fall.
- Matching: channel i hits when all of the following hold: match_en[i], match_lo_i <= addr <= match_hi_i (unsigned compare), and match_types_i[type]. A window with lo > hi never hits.
- Filter: the event is pushed if any channel hits. If match_en is all zero, every event is pushed with a hit mask of 0.
- Full, RING=1: the push drops the head entry and sets overflow.
- Full, RING=0: the new event is discarded and overflow is set.
- Full with push and pop in the same cycle: both are performed, count is unchanged, overflow is not set.
- Pop when empty: ignored.
- clr: empties the FIFO and clears overflow. It has priority over any push or pop in the same cycle.
- Debug latch: dbg_data <= z80_do on any cycle with z80_io_wr high and z80_addr[7:0] == DEBUG_PORT. This happens regardless of the filters.
- A strobe that is high when rst deasserts does not produce an event. Tracking starts from the next rising edge of a strobe.

## Timing
- Reset values: rd_valid 0, count 0, full 0, overflow 0, dbg_data 8'h00. rd_data is don't-care while rd_valid is 0. All internal pointers and tracking state are cleared.
- Latency: the strobe falls in cycle N, the entry is written at the edge ending cycle N, and rd_valid/count reflect it in cycle N+1.
- rd_data is combinational from the head pointer. The pop takes effect at the clock edge where rd_en && rd_valid.
- Pointers wrap modulo DEPTH. count is a separate counter, not a pointer difference.
- overflow stays set until clr or rst.

## Structure
- Package sggoc_trace_pkg holds: type codes (TR_MEM_RD .. TR_IO_WR), record field offsets and widths, and a type-mask bit-order function.
- Sub-module trace_fifo is parametrised on DEPTH, WIDTH and RING. It provides push, pop, clr, count, full and overflow, with FWFT output.
- The top level contains strobe tracking, the match comparators (generate loop over NUM_MATCH) and the debug latch.

## Test plan
- Mem write 0xC010 <- 0x5A, match_en=0 -> one record 0x40C0105A; rd_valid rises one cycle after the strobe falls.
- Channel 0 window 0x0000-0x3FFF with type mask mem_rd, reads at 0x0100 (di=0x3E) and 0x8000 -> only 0x01010 03E is captured; exact rd_data = 0x0101003E.
- DEPTH=4, RING=1, push 6 events -> count=4, overflow=1, head is event 3.
- Same sequence with RING=0 -> head is event 1 and events 5-6 are lost.
- With the FIFO full, push and pop in the same cycle -> count stays 4, overflow=0. Then assert clr together with rd_en -> count=0, overflow=0.
- io_wr to port 0x01 with data 0x2A -> dbg_data=0x2A on the next cycle. Assert rst while a strobe is held high -> all outputs return to their reset values, and no event is recorded after rst deasserts until a fresh strobe edge.
